// File: rtl/updown_ctr_bank.sv
// Bank of NCH debounced up/down counters with per-channel load, wrap/saturate mode
// and status flags. Raw inc/dec inputs are synchronised, debounced and edge-detected.
module updown_ctr_bank #(
   parameter int unsigned NCH       = 4,
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned MAXVAL    = 22,
   parameter int unsigned WRAP      = 0,
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NCH-1:0]         inc,
   input  logic [NCH-1:0]         dec,
   input  logic [NCH-1:0]         load,
   input  logic [WIDTH-1:0]       load_val,
   output logic [NCH*WIDTH-1:0]   count,
   output logic [NCH-1:0]         changed,
   output logic [NCH-1:0]         at_max,
   output logic [NCH-1:0]         at_zero
);

   localparam int unsigned NIN = 2 * NCH;
   localparam int unsigned CW  = $clog2(DB_CYCLES + 1);

   localparam logic [CW-1:0]    StabLast = CW'(DB_CYCLES - 1);
   localparam logic [WIDTH-1:0] MaxV     = WIDTH'(MAXVAL);
   localparam logic [WIDTH-1:0] ZeroV    = '0;
   localparam logic [WIDTH-1:0] OneV     = WIDTH'(1);

   // inc channels occupy the low half, dec channels the high half
   logic [NIN-1:0] raw;
   logic [NIN-1:0] sync1_q, sync2_q;
   logic [NIN-1:0] db_q, db_d, db_prev_q;
   logic [CW-1:0]  stab_q [NIN];
   logic [CW-1:0]  stab_d [NIN];
   logic [NIN-1:0] rise;
   logic [NCH-1:0] inc_ev, dec_ev;

   logic [WIDTH-1:0] cnt_q [NCH];
   logic [WIDTH-1:0] cnt_d [NCH];
   logic [NCH-1:0]   changed_q, changed_d;
   logic [WIDTH-1:0] load_clamped;

   assign raw          = {dec, inc};
   assign rise         = db_q & ~db_prev_q;
   assign inc_ev       = rise[NCH-1:0];
   assign dec_ev       = rise[NIN-1:NCH];
   assign load_clamped = (load_val > MaxV) ? MaxV : load_val;

   always_comb begin
      for (int j = 0; j < NIN; j++) begin
         stab_d[j] = stab_q[j];
         db_d[j]   = db_q[j];
         if (sync2_q[j] != db_q[j]) begin
            if (stab_q[j] == StabLast) begin
               db_d[j]   = ~db_q[j];
               stab_d[j] = '0;
            end else begin
               stab_d[j] = stab_q[j] + CW'(1);
            end
         end else begin
            stab_d[j] = '0;
         end
      end
   end

   always_comb begin
      changed_d = '0;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (load[i]) begin
            cnt_d[i] = load_clamped;
         end else if (inc_ev[i] && !dec_ev[i]) begin
            if (cnt_q[i] == MaxV) begin
               cnt_d[i] = (WRAP != 0) ? ZeroV : MaxV;
            end else begin
               cnt_d[i] = cnt_q[i] + OneV;
            end
         end else if (dec_ev[i] && !inc_ev[i]) begin
            if (cnt_q[i] == ZeroV) begin
               cnt_d[i] = (WRAP != 0) ? MaxV : ZeroV;
            end else begin
               cnt_d[i] = cnt_q[i] - OneV;
            end
         end
         changed_d[i] = (cnt_d[i] != cnt_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         changed_q <= '0;
         for (int j = 0; j < NIN; j++) begin
            stab_q[j] <= '0;
         end
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         changed_q <= changed_d;
         for (int j = 0; j < NIN; j++) begin
            stab_q[j] <= stab_d[j];
         end
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      count   = '0;
      at_max  = '0;
      at_zero = '0;
      for (int i = 0; i < NCH; i++) begin
         count[i*WIDTH +: WIDTH] = cnt_q[i];
         at_max[i]               = (cnt_q[i] == MaxV);
         at_zero[i]              = (cnt_q[i] == ZeroV);
      end
   end

   assign changed = changed_q;

endmodule

// File: doc/updown_ctr_bank.md
Name: updown_ctr_bank

Overview:
- Bank of NCH independent up/down counters driven by raw push-button-style inputs.
- Each input has a 2-flop synchroniser, a debouncer and rising-edge detection. One clean event equals one step.
- Parametrised successor of the single-channel increment counter. Adds decrement, wrap/saturate mode, parallel load, debouncing and status flags.
- Sits between the board KEY/SW inputs (inverted at top level to active-high) and the seg7 decoders.

Parameters:
- NCH, 4: number of counter channels (>=1).
- WIDTH, 5: bits per counter.
- MAXVAL, 22: upper count limit, common to all channels. Must satisfy 1 <= MAXVAL <= 2^WIDTH-1.
- WRAP, 0: 0 = saturate at 0/MAXVAL; 1 = wrap around (MAXVAL->0 on inc, 0->MAXVAL on dec).
- DB_CYCLES, 4: consecutive clk cycles a synchronised input must differ from its debounced value before the debounced value flips (>=1).

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high.
- inc  in  NCH  raw active-high increment requests, asynchronous to clk.
- dec  in  NCH  raw active-high decrement requests, asynchronous to clk.
- load  in  NCH  synchronous per-channel load enables. Already in clk domain; not debounced.
- load_val  in  WIDTH  value shared by all channels being loaded.
- count  out  NCH*WIDTH  packed counters; channel i occupies bits [i*WIDTH +: WIDTH].
- changed  out  NCH  one-cycle pulse per channel when its count value changes.
- at_max  out  NCH  channel count == MAXVAL (combinational from count register).
- at_zero  out  NCH  channel count == 0 (combinational from count register).

Behaviour:
- Reset (synchronous, any cycle, overrides everything):
  - Clears count, changed, sync flops, debounced values, stability counters and edge-detect history.
  - Afterwards: count=0, changed=0, at_zero=all 1s, at_max=0.
  - Reset mid-debounce discards the pending event.
  - An input held high through reset is treated as a fresh press: one event after debounce.
- Synchroniser: two flops per raw input (2*NCH inputs total).
- Debouncer, per input:
  - Stability counter, width $clog2(DB_CYCLES+1).
  - On each edge where sync output != debounced value: if counter == DB_CYCLES-1, flip debounced value and clear counter; else counter+1.
  - On each edge where sync output == debounced value: clear counter.
  - A pulse shorter than DB_CYCLES synchronised cycles produces no event.
- Event: debounced value rose (debounced & ~prev_debounced). Falling edges ignored; holding an input yields exactly one event.
- Latency: raw input rising before clk edge 1 and held stable produces the count update at edge DB_CYCLES+3. changed pulses in the cycle after that edge, aligned with the new count.
- Per-channel next-state priority:
  - 1) reset.
  - 2) load: count <= min(load_val, MAXVAL). Concurrent inc/dec events that cycle are dropped.
  - 3) inc event and dec event in the same cycle: no change.
  - 4) inc event only: count < MAXVAL -> +1; count == MAXVAL -> MAXVAL if WRAP=0, 0 if WRAP=1.
  - 5) dec event only: count > 0 -> -1; count == 0 -> 0 if WRAP=0, MAXVAL if WRAP=1.
- Arithmetic: all arithmetic is WIDTH bits with explicitly sized constants; no intermediate overflow at MAXVAL = 2^WIDTH-1.
- changed: registered; 1 iff the count register took a different value on the previous edge. A saturating no-op or a load of an equal value gives changed=0.
- Channel independence: channels are fully independent; activity on one never affects another.

Test Plan:
- Use NCH=4, WIDTH=5, MAXVAL=22, DB_CYCLES=4 unless stated.
- Reset, then inc[0]=1 held 20 cycles -> count0 goes 0->1 exactly once, at edge 7 after assertion. changed[0] high one cycle. Other channels remain 0.
- inc[2] high for 2 cycles, then low -> no count change, changed=0. Then inc[2] high for 6 cycles -> count2=1.
- load[1]=1 with load_val=31 -> count1=22, at_max[1]=1. Then inc[1] press -> stays 22, changed[1]=0. Repeat with WRAP=1 -> count1=0, at_zero[1]=1, changed[1] pulse.
- From reset, dec[3] press -> count3=0 (WRAP=0). With WRAP=1 -> count3=22.
- count1=5; inc[1] and dec[1] presses debounced on the same edge -> count1 stays 5. load[1]=1 with load_val=9 in the same cycle as an inc event -> count1=9, not 10.
- count0=4; inc[0] asserted, reset pulsed 3 cycles later, inc[0] released before debounce completes -> count0=0 after reset, no increment afterwards.
